// File: rtl/counter_hex_n_pkg.sv
// Shared definitions for the counter_hex_n display counter.
//   - SEG_0..SEG_F : active-low seven-segment font, bit 6 = g ... bit 0 = a
//   - SEG_BLANK    : all segments off
//   - mode_e       : limit behaviour, MODE_WRAP = 0, MODE_SAT = 1
package counter_hex_n_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

endpackage

// File: rtl/hex_decoder.sv
// Hex nibble to active-low seven-segment decoder.
//   nibble : 4-bit value to show
//   seg    : segments, bit 6 = g ... bit 0 = a, 0 = lit
module hex_decoder
   import counter_hex_n_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      unique case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/counter_hex_n.sv
// Up/down counter with load, programmable terminal value, wrap/saturate
// limits and a multi-digit hex readout.
//   Clock     : rising-edge clock
//   Clear     : synchronous active-high reset, beats every other input
//   Enable    : count enable
//   Up        : 1 = increment, 0 = decrement
//   Sat       : 0 = wrap at limits, 1 = saturate at limits
//   Load      : synchronous load of min(LoadValue, MAX_COUNT), beats Enable
//   LoadValue : load data
//   Q         : registered count
//   TC        : registered pulse, high in the cycle after a limit event
//   Ovf       : registered sticky limit flag, cleared by Clear or Load
//   HEX       : active-low digits, digit k at HEX[7k+6:7k]
module counter_hex_n
   import counter_hex_n_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter int               NDIG      = (WIDTH + 3) / 4,
   parameter bit               BLANK_LZ  = 1'b0
) (
   input  logic                Clock,
   input  logic                Clear,
   input  logic                Enable,
   input  logic                Up,
   input  logic                Sat,
   input  logic                Load,
   input  logic [WIDTH-1:0]    LoadValue,
   output logic [WIDTH-1:0]    Q,
   output logic                TC,
   output logic                Ovf,
   output logic [7*NDIG-1:0]   HEX
);

   logic [WIDTH-1:0] q_nxt;
   logic             tc_nxt;
   logic             ovf_nxt;
   mode_e            mode;

   assign mode = mode_e'(Sat);

   // Limit tests use >= so a count above MAX_COUNT can never persist.
   always_comb begin
      q_nxt   = Q;
      tc_nxt  = 1'b0;
      ovf_nxt = Ovf;
      if (Load) begin
         q_nxt   = (LoadValue > MAX_COUNT) ? MAX_COUNT : LoadValue;
         ovf_nxt = 1'b0;
      end else if (Enable) begin
         if (Up) begin
            if (Q >= MAX_COUNT) begin
               q_nxt   = (mode == MODE_SAT) ? MAX_COUNT : '0;
               tc_nxt  = 1'b1;
               ovf_nxt = 1'b1;
            end else begin
               q_nxt = Q + WIDTH'(1);
            end
         end else begin
            if (Q == '0) begin
               q_nxt   = (mode == MODE_SAT) ? '0 : MAX_COUNT;
               tc_nxt  = 1'b1;
               ovf_nxt = 1'b1;
            end else begin
               q_nxt = Q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         Q   <= '0;
         TC  <= 1'b0;
         Ovf <= 1'b0;
      end else begin
         Q   <= q_nxt;
         TC  <= tc_nxt;
         Ovf <= ovf_nxt;
      end
   end

   // Display path: Q zero-extended across NDIG nibbles.
   logic [NDIG-1:0][3:0] nib;
   logic [NDIG-1:0][6:0] seg_raw;
   logic [NDIG-1:0]      dig_nz;
   logic [NDIG-1:0]      blank;

   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      for (genvar b = 0; b < 4; b++) begin : g_bit
         if (4*k + b < WIDTH) begin : g_in
            assign nib[k][b] = Q[4*k + b];
         end else begin : g_pad
            assign nib[k][b] = 1'b0;
         end
      end
      assign dig_nz[k] = |nib[k];
      hex_decoder u_dec (
         .nibble (nib[k]),
         .seg    (seg_raw[k])
      );
      assign HEX[7*k +: 7] = blank[k] ? SEG_BLANK : seg_raw[k];
   end

   // A digit blanks only when it and every digit above it are zero;
   // digit 0 always shows so a zero count still reads "0".
   always_comb begin
      logic higher;
      higher = 1'b0;
      blank  = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         higher   = higher | dig_nz[k];
         blank[k] = BLANK_LZ && (k != 0) && !higher;
      end
   end

endmodule

// File: doc/counter_hex_n.md
Name: counter_hex_n

Overview:
- Parametrised binary up/down counter with synchronous load, programmable terminal value, wrap or saturate mode, and a built-in multi-digit seven-segment readout.
- Successor to the fixed 8-bit enable/clear counter feeding two hex digits; generalises width, digit count and modulus, and adds direction, load, terminal-count and overflow reporting.
- Sits between board switches/keys and the HEX display bank. Also usable as a timebase or event counter inside larger lab designs.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MAX_COUNT, 2**WIDTH-1, terminal (highest legal) count; must be < 2**WIDTH.
- NDIG, (WIDTH+3)/4, number of hex digits driven on HEX.
- BLANK_LZ, 0, 1 = blank leading-zero digits on the display.

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  synchronous, active-high reset.
- Enable  in  1  count enable.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Sat  in  1  mode: 0 = wrap at limits, 1 = saturate at limits.
- Load  in  1  synchronous parallel load.
- LoadValue  in  WIDTH  value for Load.
- Q  out  WIDTH  current count (registered).
- TC  out  1  one-cycle terminal-count pulse (registered).
- Ovf  out  1  sticky limit-hit flag (registered).
- HEX  out  7*NDIG  active-low segments; digit k at HEX[7k+6:7k], bit 6 = g … bit 0 = a.

Behaviour:
- Reset: at a rising Clock with Clear=1, Q=0, TC=0, Ovf=0. There is no asynchronous path. Clear mid-count discards all other inputs that cycle.
- Priority per edge: Clear > Load > Enable > hold.
- Load=1: Q <= min(LoadValue, MAX_COUNT); Ovf <= 0; TC <= 0. Enable is ignored.
- Enable=1, Up=1:
  - Q < MAX_COUNT: Q <= Q+1.
  - Q == MAX_COUNT: wrap mode gives Q <= 0; saturate mode holds Q. In both modes TC <= 1 and Ovf <= 1.
- Enable=1, Up=0:
  - Q > 0: Q <= Q-1.
  - Q == 0: wrap mode gives Q <= MAX_COUNT; saturate mode holds Q. In both modes TC <= 1 and Ovf <= 1.
- TC:
  - High for exactly the one cycle following a limit event, aligned with the new Q value. Otherwise 0.
  - Consecutive limit events in saturate mode keep TC high every cycle.
- Ovf: remains 1 until Clear or Load.
- Enable=0, Load=0: Q and Ovf hold; TC <= 0.
- Direction or mode change takes effect on the same edge it is sampled. No pipeline.
- Q out of range (only possible if MAX_COUNT changes between builds) is never produced. Arithmetic is modulo 2**WIDTH internally, then limit-checked.
- HEX:
  - Combinational from Q; zero-extended to 4*NDIG bits.
  - Standard active-low hex font 0-F, identical to the existing hex_decoder.
  - BLANK_LZ=1: a digit k>0 is driven 7'h7F when it and all higher digits are zero. Digit 0 is never blanked.
  - Digits above WIDTH always show 0, or blank when BLANK_LZ=1.
- Latency: input to Q/TC/Ovf is 1 cycle; Q to HEX is 0 cycles.

Decomposition:
- Shared package holds:
  - segment font constants SEG_0..SEG_F.
  - SEG_BLANK = 7'h7F.
  - mode encodings MODE_WRAP = 0, MODE_SAT = 1.
- Sub-module: reuse hex_decoder (4-bit in, 7-bit active-low out), instantiated NDIG times in a generate loop.
- Counter core and blanking logic stay in counter_hex_n.

Test Plan:
- Reset and hold:
  - Stimulus: Clear=1 for 2 cycles with Enable=1, Up=1.
  - Response: Q=0, TC=0, Ovf=0, HEX (WIDTH=8) = {7'h40, 7'h40}. Then Enable=0 for 5 cycles keeps Q=0.
- Up wrap (WIDTH=8, MAX_COUNT=9, Sat=0):
  - Stimulus: count from 0 for 11 enabled cycles.
  - Response: Q goes 0…9,0,1. TC is high only in the cycle Q becomes 0. Ovf=1 thereafter.
- Down saturate (Sat=0 → Sat=1, Up=0):
  - Stimulus: Load 2, then 4 enabled cycles.
  - Response: Q goes 2,1,0,0,0. TC is high on the two cycles Q is held at 0. Ovf=1.
- Load priority and clamp (MAX_COUNT=9):
  - Stimulus: Load=1 with LoadValue=8'hC8 and Enable=1.
  - Response: Q=9, Ovf cleared. Next Up count wraps Q to 0 with TC=1.
- Clear vs Load collision:
  - Stimulus: Clear=1, Load=1, LoadValue=5 on the same edge.
  - Response: Q=0, Ovf=0.
- Leading-zero blanking (WIDTH=12, BLANK_LZ=1):
  - Q=12'h00A → HEX = {7'h7F, 7'h7F, SEG_A}.
  - Q=12'h100 → HEX = {SEG_1, SEG_0, SEG_0}.
